// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache lookup port between requesters
module cache_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_wdata,
    input  logic [NUM_REQ-1:0]            req_we,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [IDW-1:0]                resp_id,
    output logic [7:0]                    resp_rdata,
    output logic                          resp_hit,
    output logic [ADDR_WIDTH-1:0]         cache_addr,
    output logic [7:0]                    cache_wr_data,
    output logic                          cache_wr_en,
    input  logic [7:0]                    cache_rd_data,
    input  logic                          cache_hit,
    input  logic                          cache_miss,
    output logic [CNT_WIDTH-1:0]          hit_count,
    output logic [CNT_WIDTH-1:0]          miss_count,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [IDW-1:0]          resp_id_q, resp_id_d;
    logic [7:0]              resp_rdata_q, resp_rdata_d;
    logic                    resp_hit_q, resp_hit_d;
    logic [CNT_WIDTH-1:0]    hit_q, hit_d;
    logic [CNT_WIDTH-1:0]    miss_q, miss_d;

    logic                    grant_found;
    logic [IDW-1:0]          grant_idx;
    int                      cand;

    // Round-robin search: first valid requester after the last winner, wrapping once.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // Next-state and datapath updates for the IDLE/ISSUE/CAPTURE/RESP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        resp_id_d    = resp_id_q;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    addr_d    = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = req_wdata[grant_idx*8 +: 8];
                    we_d      = req_we[grant_idx];
                    rr_ptr_d  = grant_idx;
                    resp_id_d = grant_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Cache outputs are registered, so they now reflect the ISSUE-cycle lookup.
                resp_hit_d   = cache_hit;
                resp_rdata_d = we_q ? 8'h00 : cache_rd_data;
                if (cache_hit && (hit_q != {CNT_WIDTH{1'b1}})) begin
                    hit_d = hit_q + CNT_WIDTH'(1);
                end
                if (cache_miss && (miss_q != {CNT_WIDTH{1'b1}})) begin
                    miss_d = miss_q + CNT_WIDTH'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and points rr_ptr at the last index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDW'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            resp_id_q    <= '0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            resp_id_q    <= resp_id_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // The cache looks up every cycle; outside ISSUE it replays the latched address as a read.
    always_comb begin
        cache_addr    = addr_q;
        cache_wr_en   = 1'b0;
        cache_wr_data = 8'h00;
        if (state_q == ISSUE) begin
            cache_wr_en   = we_q;
            cache_wr_data = wdata_q;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_id_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int CNT_WIDTH  = 4;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*8-1:0]          req_wdata;
    logic [NUM_REQ-1:0]            req_we;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [0:0]                    resp_id;
    logic [7:0]                    resp_rdata;
    logic                          resp_hit;
    logic [ADDR_WIDTH-1:0]         cache_addr;
    logic [7:0]                    cache_wr_data;
    logic                          cache_wr_en;
    logic [7:0]                    cache_rd_data = 8'h00;
    logic                          cache_hit = 1'b0;
    logic                          cache_miss = 1'b0;
    logic [CNT_WIDTH-1:0]          hit_count;
    logic [CNT_WIDTH-1:0]          miss_count;
    logic                          busy;

    int total  = 0;
    int passed = 0;

    cache_port_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_we        (req_we),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_rdata    (resp_rdata),
        .resp_hit      (resp_hit),
        .cache_addr    (cache_addr),
        .cache_wr_data (cache_wr_data),
        .cache_wr_en   (cache_wr_en),
        .cache_rd_data (cache_rd_data),
        .cache_hit     (cache_hit),
        .cache_miss    (cache_miss),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural cache: registered lookup every cycle, allocate on miss, write on wr_en.
    logic [7:0] cmem [logic [31:0]];
    always @(posedge clk) begin
        if (cmem.exists(cache_addr)) begin
            cache_hit     <= 1'b1;
            cache_miss    <= 1'b0;
            cache_rd_data <= cmem[cache_addr];
            if (cache_wr_en) cmem[cache_addr] = cache_wr_data;
        end else begin
            cache_hit     <= 1'b0;
            cache_miss    <= 1'b1;
            cache_rd_data <= 8'h00;
            cmem[cache_addr] = cache_wr_en ? cache_wr_data : 8'h00;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic w, input logic [7:0] d);
        req_addr[id*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_wdata[id*8 +: 8] = d;
        req_we[id] = w;
    endtask

    // Single-requester transaction with latency, response and handshake checks.
    task automatic txn(input int id, input logic [31:0] a, input logic w, input logic [7:0] d,
                       input logic exp_hit, input logic [7:0] exp_rd, input string tag);
        int waited;
        logic [1:0] exp_rdy;
        exp_rdy = 2'b01 << id;
        set_req(id, a, w, d);
        req_valid[id] = 1'b1;
        #1;
        waited = 0;
        while (req_ready == 2'b00 && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, "_ready"}, req_ready, exp_rdy);
        step();
        req_valid[id] = 1'b0;
        chk({tag, "_t1_valid"}, {busy, resp_valid}, 2'b10);
        step();
        chk({tag, "_t2_valid"}, resp_valid, 1'b0);
        step();
        chk({tag, "_t3_resp"}, {resp_valid, resp_id, resp_hit, resp_rdata},
            {1'b1, 1'(id), exp_hit, exp_rd});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_done"}, {busy, resp_valid}, 2'b00);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = '0;
        resp_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("reset_outputs", {resp_valid, busy, resp_id, resp_hit, resp_rdata, cache_wr_en},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        chk("reset_counts", {hit_count, miss_count}, 8'h00);
        chk("reset_cache_addr", cache_addr, 32'h0);

        // Test 1: first read miss from req0
        txn(0, 32'h0000_0040, 1'b0, 8'h00, 1'b0, 8'h00, "t1_rd_miss");
        chk("t1_counts", {hit_count, miss_count}, {4'd0, 4'd1});

        // Test 2: write hit returns rdata 0, read-back returns written byte
        txn(1, 32'h0000_0040, 1'b1, 8'hA5, 1'b1, 8'h00, "t2_wr");
        txn(0, 32'h0000_0040, 1'b0, 8'h00, 1'b1, 8'hA5, "t2_rd");
        chk("t2_counts", {hit_count, miss_count}, {4'd2, 4'd1});

        // Test 4: response held for 5 cycles, other requester waiting
        set_req(1, 32'h0000_0040, 1'b0, 8'h00);
        req_valid[1] = 1'b1;
        #1;
        chk("t4_ready", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        step();
        step();
        set_req(0, 32'h0000_0040, 1'b0, 8'h00);
        req_valid[0] = 1'b1;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("t4_hold", {resp_valid, resp_id, resp_hit, resp_rdata, req_ready, cache_wr_en},
                {1'b1, 1'b1, 1'b1, 8'hA5, 2'b00, 1'b0});
            step();
        end
        req_valid[0] = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t4_done", {busy, hit_count}, {1'b0, 4'd3});

        // Test 3: continuous contention alternates grants 0,1,0,1
        set_req(0, 32'h0000_0040, 1'b0, 8'h00);
        set_req(1, 32'h0000_0040, 1'b0, 8'h00);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("t3_no_ready_busy", req_ready, 2'b00);
            step();
            step();
            chk("t3_resp_id", {resp_valid, resp_id}, {1'b1, 1'((k % 2))});
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
        end
        req_valid = 2'b00;
        chk("t3_counts", {hit_count, miss_count}, {4'd7, 4'd1});

        // Test 5: reset during CAPTURE drops the transaction
        set_req(1, 32'h0000_0080, 1'b0, 8'h00);
        req_valid[1] = 1'b1;
        #1;
        chk("t5_ready", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        step();
        chk("t5_in_capture", {busy, resp_valid}, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("t5_reset_now", {busy, resp_valid, hit_count, miss_count}, 10'h000);
        step();
        reset_n = 1'b1;
        set_req(0, 32'h0000_0040, 1'b0, 8'h00);
        set_req(1, 32'h0000_0080, 1'b0, 8'h00);
        req_valid = 2'b11;
        #1;
        chk("t5_first_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("t5_resp", {resp_valid, resp_id, resp_hit, resp_rdata}, {1'b1, 1'b0, 1'b1, 8'hA5});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t5_counts", {hit_count, miss_count}, {4'd1, 4'd0});

        // Test 6: hit counter saturates at all-ones (4-bit instance)
        for (int i = 2; i <= 17; i++) begin
            txn(0, 32'h0000_0040, 1'b0, 8'h00, 1'b1, 8'hA5, "t6_rd");
            if (i == 14) chk("t6_hit_14", hit_count, 4'd14);
            if (i >= 15) chk("t6_hit_sat", hit_count, 4'hF);
        end
        chk("t6_miss", miss_count, 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
